// File: rtl/edge_pkg.sv
// edge_pkg: shared types for the Sobel frame controller.
package edge_pkg;

    localparam int PIX_W = 4;
    localparam int CRD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN,
        DRAIN
    } edge_state_t;

    typedef struct packed {
        logic [CRD_W-1:0] row;
        logic [CRD_W-1:0] col;
    } coord_t;

endpackage

// File: rtl/edge_pix_coord.sv
// edge_pix_coord: raster col/row counter with end-of-line and end-of-frame flags.
module edge_pix_coord
    import edge_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   en,
    output coord_t pos,
    output logic   last_col,
    output logic   last_pix
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign last_col = (col == COL_W'(IMG_W - 1));
    assign last_pix = last_col && (row == ROW_W'(IMG_H - 1));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign pos.col = CRD_W'(col);
    assign pos.row = CRD_W'(row);

endmodule

// File: rtl/edge_frame_ctrl.sv
// edge_frame_ctrl: frame sequencer, stall control and masked output stage for the Sobel filter.
// Start-of-frame sync and stray-SOF error detection are enabled by FRAME_CTRL_SOF_CHECK_EN.
module edge_frame_ctrl
    import edge_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] src_pixel,
    input  logic             src_valid,
    input  logic             src_sof,
    output logic             src_ready,
    output logic [PIX_W-1:0] filt_in,
    output logic             filt_en,
    input  logic [PIX_W-1:0] filt_pixel,
    output logic [PIX_W-1:0] dst_pixel,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic             dst_sof,
    output logic             dst_eol,
    output logic             dst_eof,
    output logic             busy,
    output logic             done,
    output logic             err
);

    edge_state_t state, state_nxt;
    logic        p1_valid;
    logic        out_load;
    logic        accept;
    logic        frame_arm;
    coord_t      in_pos, tag;
    logic        in_last_col, in_last;
    logic        tag_last_col, tag_last;
    logic        border_ok;

    assign out_load  = !dst_valid || dst_ready;
    assign frame_arm = (state == IDLE) && start;
    assign filt_in   = src_pixel;
    assign filt_en   = accept;
    assign busy      = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        src_ready = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef FRAME_CTRL_SOF_CHECK_EN
                    state_nxt = SYNC;
`else
                    state_nxt = RUN;
`endif
                end
            end
            SYNC: begin
                src_ready = 1'b1;
                if (src_valid && src_sof) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                src_ready = !p1_valid || out_load;
                accept    = src_valid && src_ready;
                if (accept && in_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (dst_valid && dst_ready && dst_eof) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    edge_pix_coord #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_in_coord (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_arm),
        .en       (accept),
        .pos      (in_pos),
        .last_col (in_last_col),
        .last_pix (in_last)
    );

    // The tag of the beat held in P1 is the coordinate of the next beat to enter OUT.
    edge_pix_coord #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_tag_coord (
        .clk      (clk),
        .rst      (rst),
        .clr      (frame_arm),
        .en       (out_load && p1_valid),
        .pos      (tag),
        .last_col (tag_last_col),
        .last_pix (tag_last)
    );

    assign border_ok = (tag.row >= CRD_W'(2)) && (tag.col >= CRD_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid  <= 1'b0;
            dst_valid <= 1'b0;
            dst_pixel <= '0;
            dst_sof   <= 1'b0;
            dst_eol   <= 1'b0;
            dst_eof   <= 1'b0;
        end else begin
            if (out_load) begin
                dst_valid <= p1_valid;
                dst_pixel <= (p1_valid && border_ok) ? filt_pixel : '0;
                dst_sof   <= p1_valid && (tag == '0);
                dst_eol   <= p1_valid && tag_last_col;
                dst_eof   <= p1_valid && tag_last;
            end
            if (accept)        p1_valid <= 1'b1;
            else if (out_load) p1_valid <= 1'b0;
        end
    end

`ifdef FRAME_CTRL_SOF_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if ((state == RUN) && accept && src_sof && (in_pos != '0)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    logic unused_in;
    assign unused_in = &{1'b0, in_pos, in_last_col};

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// tb_edge_frame_ctrl: randomized frame traffic against a stream-level reference model and a Sobel filter model.
module tb_edge_frame_ctrl;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;
    localparam int BUDGET = 3000;

    typedef enum int {PH_IDLE, PH_SYNC, PH_RUN, PH_DRAIN} phase_t;
    typedef enum int {IMG_RAMP, IMG_STEP, IMG_RAND} img_t;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       src_valid = 1'b0, src_sof = 1'b0, dst_ready = 1'b0;
    logic [3:0] src_pixel = '0;
    logic [3:0] filt_pixel, filt_in, dst_pixel;
    logic       src_ready, filt_en, dst_valid, dst_sof, dst_eol, dst_eof, busy, done, err;

    int         n_tests = 0, n_fail = 0;
    phase_t     phase = PH_IDLE;
    int         acc_n = 0, out_n = 0, cyc = 0;
    int         first_acc = -1, first_dv = -1, done_cyc = -1, done_seen = 0, nz_cnt = 0;
    logic       err_exp = 1'b0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_val = '0;
    logic [3:0] src_img [N];

    edge_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_pixel(src_pixel), .src_valid(src_valid), .src_sof(src_sof), .src_ready(src_ready),
        .filt_in(filt_in), .filt_en(filt_en), .filt_pixel(filt_pixel),
        .dst_pixel(dst_pixel), .dst_valid(dst_valid), .dst_ready(dst_ready),
        .dst_sof(dst_sof), .dst_eol(dst_eol), .dst_eof(dst_eof),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Golden 3x3 Sobel: (|gx|+|gy|)/8 saturated to 4 bits, window centred on (r,c).
    function automatic logic [3:0] sobel_at(input logic [3:0] img [N], input int r, input int c);
        int p [3][3];
        int gx, gy, m;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = int'(img[(r - 1 + i) * W + (c - 1 + j)]);
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        m  = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> 3;
        return (m > 15) ? 4'd15 : 4'(m);
    endfunction

    // Filter model: free-running window over the beats it was advanced with; junk at borders.
    logic [3:0] fimg [N];
    int         fpos, flast;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fpos  <= 0;
            flast <= -1;
        end else if (filt_en) begin
            fimg[fpos] <= filt_in;
            flast      <= fpos;
            fpos       <= (fpos == N - 1) ? 0 : fpos + 1;
        end
    end

    function automatic logic [3:0] filt_model(input logic [3:0] img [N], input int idx);
        int r, c;
        if (idx < 0) return 4'd0;
        r = idx / W;
        c = idx % W;
        if (r < 2 || c < 2) return 4'((idx * 5 + 9) % 16);
        return sobel_at(img, r - 1, c - 1);
    endfunction

    always_comb filt_pixel = filt_model(fimg, flast);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] pix_for(input img_t mode, input int k);
        case (mode)
            IMG_RAMP: return 4'(k % 16);
            IMG_STEP: return ((k % W) < 4) ? 4'd0 : 4'd15;
            default:  return 4'($urandom_range(15));
        endcase
    endfunction

    // One clock: sample at negedge+1, compare with the model, then advance the model over the edge.
    task automatic tick();
        logic exp_ready, exp_acc, exp_done, hs;
        logic [3:0] ep, cap_pix;
        logic cap_sof, cap_start;
        int fl, r, c;
        #1;
        fl = acc_n - out_n;
        case (phase)
            PH_SYNC: exp_ready = 1'b1;
            PH_RUN:  exp_ready = (fl < 2) || dst_ready;
            default: exp_ready = 1'b0;
        endcase
        exp_acc = (phase == PH_SYNC) ? (src_valid && src_sof)
                                     : ((phase == PH_RUN) && src_valid && exp_ready);
        check("src_ready", src_ready, exp_ready);
        check("filt_en", filt_en, exp_acc);
        if (exp_acc) check("filt_in", filt_in, src_pixel);
        check("busy", busy, phase != PH_IDLE);
        check("err", err, err_exp);
        exp_done = (phase == PH_DRAIN) && dst_valid && dst_ready && (out_n == N - 1);
        check("done", done, exp_done);
        if (hold_prev) check("hold", {dst_valid, dst_pixel, dst_sof, dst_eol, dst_eof}, hold_val);
        if (dst_valid) begin
            if (first_dv < 0) first_dv = cyc;
            check("dv_extra", 32'(out_n < acc_n), 1);
            if (out_n < acc_n) begin
                r  = out_n / W;
                c  = out_n % W;
                ep = (r >= 2 && c >= 2) ? sobel_at(src_img, r - 1, c - 1) : 4'd0;
                check($sformatf("beat%0d", out_n), {dst_pixel, dst_sof, dst_eol, dst_eof},
                      {ep, out_n == 0, c == W - 1, out_n == N - 1});
            end
        end
        hs        = dst_valid && dst_ready;
        if (hs && dst_pixel != 4'd0) nz_cnt++;
        hold_prev = dst_valid && !dst_ready;
        hold_val  = {dst_valid, dst_pixel, dst_sof, dst_eol, dst_eof};
        cap_pix   = src_pixel;
        cap_sof   = src_sof;
        cap_start = start;
        @(posedge clk);
        if (exp_acc) begin
`ifdef FRAME_CTRL_SOF_CHECK_EN
            if (phase == PH_RUN && cap_sof && acc_n != 0) err_exp = 1'b1;
`endif
            src_img[acc_n] = cap_pix;
            if (first_acc < 0) first_acc = cyc;
            acc_n++;
            if (phase == PH_SYNC) phase = PH_RUN;
            if (acc_n == N) phase = PH_DRAIN;
        end
        if (hs) out_n++;
        if (exp_done) begin
            phase    = PH_IDLE;
            done_cyc = cyc;
            done_seen++;
        end else if (phase == PH_IDLE && cap_start) begin
`ifdef FRAME_CTRL_SOF_CHECK_EN
            phase = PH_SYNC;
`else
            phase = PH_RUN;
`endif
            acc_n = 0; out_n = 0; first_acc = -1; first_dv = -1; done_seen = 0; nz_cnt = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_sof = 1'b0; dst_ready = 1'b0;
        #1;
        check("rst_outputs", {src_ready, filt_en, dst_valid, dst_sof, dst_eol, dst_eof,
                              busy, done, err, dst_pixel}, '0);
        phase = PH_IDLE; acc_n = 0; out_n = 0; err_exp = 1'b0; hold_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0; src_valid = 1'b1; src_pixel = 4'($urandom_range(15));
            src_sof = 1'b0; dst_ready = 1'b1;
            tick();
        end
    endtask

    task automatic run_frame(input img_t mode, input int vpct, input int rpct, input int stall_at,
                             input int junk, input int stray, input int abort_at, input bit full_rate);
        int budget = 0, stall_left = 0, junk_left = junk;
        bit stalled = 1'b0;
        start = 1'b1; src_valid = 1'b0; src_sof = 1'b0; dst_ready = 1'b1;
        tick();
        while (phase != PH_IDLE && budget < BUDGET) begin
            src_valid = ($urandom_range(99) < vpct);
            src_pixel = pix_for(mode, acc_n);
`ifdef FRAME_CTRL_SOF_CHECK_EN
            if (phase == PH_SYNC) begin
                src_sof = (junk_left == 0);
                if (src_valid && !src_sof) junk_left--;
            end else begin
                src_sof = (stray >= 0) && (acc_n == stray);
            end
`else
            src_sof = 1'($urandom_range(1));
`endif
            if (!stalled && acc_n == stall_at) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                dst_ready = 1'b0;
                stall_left--;
            end else begin
                dst_ready = ($urandom_range(99) < rpct);
            end
            start = (phase != PH_IDLE) && ($urandom_range(3) == 0);
            tick();
            budget++;
            if (abort_at >= 0 && acc_n == abort_at) begin
                apply_reset();
                return;
            end
        end
        start = 1'b0;
        check("frame_timeout", 32'(budget < BUDGET), 1);
        check("done_once", done_seen, 1);
        check("out_count", out_n, N);
        if (full_rate) begin
            check("latency", first_dv - first_acc, 2);
            check("throughput", done_cyc - first_acc, N + 1);
        end
        if (mode == IMG_STEP) check("step_nonzero", nz_cnt, 4);
    endtask

    initial begin
        @(negedge clk);
        apply_reset();
        idle_ticks(4);
        run_frame(IMG_RAMP, 100, 100, -1, 0, -1, -1, 1'b1);
        run_frame(IMG_RAMP, 100, 100, 11, 0, -1, -1, 1'b0);
        run_frame(IMG_STEP, 70, 70, -1, 0, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_frame(IMG_RAND, 30 + $urandom_range(70), 30 + $urandom_range(70), -1, 0, -1, -1, 1'b0);
        run_frame(IMG_RAND, 100, 80, -1, 0, -1, 13, 1'b0);
        idle_ticks(2);
        run_frame(IMG_RAMP, 100, 100, -1, 0, -1, -1, 1'b1);
`ifdef FRAME_CTRL_SOF_CHECK_EN
        run_frame(IMG_RAMP, 80, 80, -1, 3, 11, -1, 1'b0);
        idle_ticks(3);
        check("err_sticky", err, 1'b1);
        apply_reset();
        check("err_cleared", err, 1'b0);
        run_frame(IMG_RAND, 90, 90, -1, 2, -1, -1, 1'b0);
`endif
        idle_ticks(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
